// File: rtl/goomba_pkg.sv
// rtl/goomba_pkg.sv - shared types and constants for the goomba spawn controller
package goomba_pkg;

    localparam logic [7:0] END_COL    = 8'hFF;
    localparam logic [7:0] SCROLL_MAX = 8'hFE;

    typedef struct packed {
        logic [7:0] col;
        logic [9:0] y;
    } spawn_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_ALLOC,
        ST_ISSUE,
        ST_CONFIRM,
        ST_DONE
    } spawn_state_t;

    // Column offset is at most the visible width, so the product stays inside 10 bits.
    function automatic logic [9:0] col_to_x(input logic [7:0] off,
                                            input logic [9:0] x_min,
                                            input logic [9:0] tile_w);
        return x_min + 10'(off) * tile_w;
    endfunction

endpackage

// File: rtl/goomba_spawn_rom.sv
// rtl/goomba_spawn_rom.sv - combinational per-level spawn table
module goomba_spawn_rom
    import goomba_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic [ADDR_W-1:0] addr,
    output spawn_entry_t      entry
);

    always_comb begin
        entry = '{col: END_COL, y: 10'd0};
        case (int'(addr))
            0:       entry = '{col: 8'd3,  y: 10'd400};
            1:       entry = '{col: 8'd5,  y: 10'd380};
            2:       entry = '{col: 8'd12, y: 10'd400};
            3:       entry = '{col: 8'd1,  y: 10'd300};
            4:       entry = '{col: 8'd6,  y: 10'd360};
            5:       entry = '{col: 8'd7,  y: 10'd400};
            6:       entry = '{col: 8'd8,  y: 10'd350};
            default: entry = '{col: END_COL, y: 10'd0};
        endcase
    end

endmodule

// File: rtl/goomba_spawner.sv
// rtl/goomba_spawner.sv - allocates goomba instances as spawn table entries scroll into view
module goomba_spawner
    import goomba_pkg::*;
#(
    parameter int         NUM_SLOTS   = 4,
    parameter int         NUM_ENTRIES = 16,
    parameter logic [9:0] X_MIN       = 10'd120,
    parameter logic [9:0] TILE_W      = 10'd40,
    parameter int         VIS_COLS    = 9
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_clk,
    input  logic                 level_start,
    input  logic                 kill_all,
    input  logic                 Shift,
    input  logic [NUM_SLOTS-1:0] slot_alive,
    output logic [NUM_SLOTS-1:0] start,
    output logic [NUM_SLOTS-1:0] kill,
    output logic [9:0]           spawnX,
    output logic [9:0]           spawnY,
    output logic [7:0]           scroll_col,
    output logic                 done,
    output logic                 spawn_err
);

    localparam int ADDR_W = $clog2(NUM_ENTRIES);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    spawn_state_t      state, state_nxt;
    spawn_entry_t      entry;
    logic [PTR_W-1:0]  ptr;
    logic [SLOT_W-1:0] slot_q, free_idx;
    logic [7:0]        off_q, col_diff;
    logic              conf_q, frame_q, frame_rise, free_found, entry_end;
    logic              ptr_clr, ptr_inc, latch_off, latch_spawn, set_err, conf_set;

    goomba_spawn_rom #(.ADDR_W(ADDR_W)) u_rom (
        .addr  (ptr[ADDR_W-1:0]),
        .entry (entry)
    );

    assign frame_rise = frame_clk & ~frame_q;
    assign col_diff   = entry.col - scroll_col;
    assign entry_end  = (ptr >= PTR_W'(NUM_ENTRIES)) || (entry.col == END_COL);
    assign done       = (state == ST_DONE);

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_alive[i]) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        start       = '0;
        kill        = '0;
        ptr_clr     = 1'b0;
        ptr_inc     = 1'b0;
        latch_off   = 1'b0;
        latch_spawn = 1'b0;
        set_err     = 1'b0;
        conf_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (level_start) begin
                    ptr_clr   = 1'b1;
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (entry_end) begin
                    state_nxt = ST_DONE;
                end else if (entry.col < scroll_col) begin
                    ptr_inc = 1'b1;
                end else if (col_diff <= 8'(VIS_COLS)) begin
                    latch_off = 1'b1;
                    state_nxt = ST_ALLOC;
                end
            end
            ST_ALLOC: begin
                if (free_found) begin
                    latch_spawn = 1'b1;
                    state_nxt   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                start[slot_q] = 1'b1;
                state_nxt     = ST_CONFIRM;
            end
            ST_CONFIRM: begin
                if (slot_alive[slot_q]) begin
                    ptr_inc   = 1'b1;
                    state_nxt = ST_SCAN;
                end else if (conf_q) begin
                    set_err   = 1'b1;
                    ptr_inc   = 1'b1;
                    state_nxt = ST_SCAN;
                end else begin
                    conf_set = 1'b1;
                end
            end
            ST_DONE: begin
                if (level_start) begin
                    ptr_clr   = 1'b1;
                    state_nxt = ST_SCAN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Restarting a running level tears down every live instance first.
        if (level_start && state != ST_IDLE) begin
            kill        = '1;
            start       = '0;
            ptr_clr     = 1'b1;
            ptr_inc     = 1'b0;
            latch_off   = 1'b0;
            latch_spawn = 1'b0;
            set_err     = 1'b0;
            conf_set    = 1'b0;
            state_nxt   = ST_SCAN;
        end
        if (kill_all) begin
            kill        = '1;
            start       = '0;
            ptr_clr     = 1'b1;
            ptr_inc     = 1'b0;
            latch_off   = 1'b0;
            latch_spawn = 1'b0;
            set_err     = 1'b0;
            conf_set    = 1'b0;
            state_nxt   = ST_IDLE;
        end
        if (Reset) begin
            start = '0;
            kill  = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            slot_q     <= '0;
            off_q      <= '0;
            conf_q     <= 1'b0;
            frame_q    <= 1'b0;
            spawnX     <= '0;
            spawnY     <= '0;
            scroll_col <= '0;
            spawn_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            frame_q <= frame_clk;
            conf_q  <= conf_set;
            if (ptr_clr) begin
                ptr <= '0;
            end else if (ptr_inc) begin
                ptr <= ptr + 1'b1;
            end
            // Offset is frozen on entering ALLOC so scrolling while waiting for a slot cannot skew spawnX.
            if (latch_off) begin
                off_q <= col_diff;
            end
            if (latch_spawn) begin
                slot_q <= free_idx;
                spawnX <= col_to_x(off_q, X_MIN, TILE_W);
                spawnY <= entry.y;
            end
            if (set_err) begin
                spawn_err <= 1'b1;
            end
            if (kill_all || level_start) begin
                scroll_col <= '0;
            end else if (frame_rise && Shift && scroll_col != SCROLL_MAX) begin
                scroll_col <= scroll_col + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_goomba_spawner.sv
// tb/tb_goomba_spawner.sv - directed self-checking bench for goomba_spawner
module tb_goomba_spawner;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       level_start = 1'b0;
    logic       kill_all = 1'b0;
    logic       Shift = 1'b0;
    logic [3:0] slot_alive = 4'b0000;
    logic [3:0] start, kill;
    logic [9:0] spawnX, spawnY;
    logic [7:0] scroll_col;
    logic       done, spawn_err;

    goomba_spawner dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .level_start (level_start),
        .kill_all    (kill_all),
        .Shift       (Shift),
        .slot_alive  (slot_alive),
        .start       (start),
        .kill        (kill),
        .spawnX      (spawnX),
        .spawnY      (spawnY),
        .scroll_col  (scroll_col),
        .done        (done),
        .spawn_err   (spawn_err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0] slot;
        logic [9:0] x;
        logic [9:0] y;
    } spawn_t;

    spawn_t     exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         n;
    logic [3:0] mute = 4'b0000;
    logic [3:0] last_start = 4'b0000;
    logic [3:0] last_kill = 4'b0000;
    int         m_scroll = 0;
    logic       m_prev = 1'b0;
    logic       m_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // One clock: compare outputs against the model at negedge, advance model and instances.
    task automatic tick();
        logic [3:0] nxt;
        logic [3:0] exp_kill;
        spawn_t     e;
        @(negedge Clk);
        last_start = start;
        last_kill  = kill;
        if (Reset)                                    exp_kill = 4'b0000;
        else if (kill_all || (level_start && m_active)) exp_kill = 4'b1111;
        else                                          exp_kill = 4'b0000;
        check("kill", kill, exp_kill);
        check("scroll_col", scroll_col, m_scroll);
        check("start_onehot_disjoint", ($countones(start) <= 1) && ((start & kill) == 4'b0000), 1);
        if (start != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_start", start, 0);
            end else begin
                e = exp_q.pop_front();
                check("start_slot", start, e.slot);
                check("spawnX", spawnX, e.x);
                check("spawnY", spawnY, e.y);
            end
        end
        if (Reset || kill_all || level_start)           m_scroll = 0;
        else if (frame_clk && !m_prev && Shift && m_scroll < 254) m_scroll++;
        m_prev = Reset ? 1'b0 : frame_clk;
        if (Reset || kill_all) m_active = 1'b0;
        else if (level_start)  m_active = 1'b1;
        nxt = slot_alive;
        for (int i = 0; i < 4; i++) begin
            if (kill[i])                  nxt[i] = 1'b0;
            else if (start[i] && !mute[i]) nxt[i] = 1'b1;
        end
        @(posedge Clk);
        #1;
        slot_alive = nxt;
    endtask

    task automatic wait_start(input int max, output int cnt);
        cnt = 0;
        last_start = 4'b0000;
        while (last_start == 4'b0000 && cnt < max) begin
            tick();
            cnt++;
        end
        check("start_seen", last_start != 4'b0000, 1);
    endtask

    task automatic frame();
        frame_clk = 1'b1;
        Shift = 1'b1;
        tick();
        frame_clk = 1'b0;
        Shift = 1'b0;
        tick();
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        tick();
        check("rst_start", last_start, 0);
        check("rst_kill", last_kill, 0);
        check("rst_spawnX", spawnX, 0);
        check("rst_spawnY", spawnY, 0);
        check("rst_done", done, 0);
        check("rst_spawn_err", spawn_err, 0);
        Reset = 1'b0;
        tick();

        // entry0 col 3 at scroll 0 -> slot 0, x = 120 + 3*40
        exp_q.push_back('{4'b0001, 10'd240, 10'd400});
        level_start = 1'b1;
        tick();
        level_start = 1'b0;
        wait_start(8, n);
        check("latency_scan_alloc_issue", n, 3);

        // every slot busy: entry1 waits in ALLOC until slot 2 frees
        slot_alive = 4'b1111;
        repeat (6) tick();
        check("hold_no_start", last_start, 0);
        exp_q.push_back('{4'b0100, 10'd320, 10'd380});
        slot_alive[2] = 1'b0;
        wait_start(6, n);

        // entry2 col 12 is off screen until scroll_col reaches 3
        repeat (8) tick();
        check("far_no_start", last_start, 0);
        slot_alive[1] = 1'b0;
        exp_q.push_back('{4'b0010, 10'd480, 10'd400});
        repeat (3) frame();
        check("scroll_after_3", scroll_col, 3);
        wait_start(8, n);

        // entry3 col 1 is behind the screen and skipped; entry4 goes to a slot that never comes alive
        slot_alive[3] = 1'b0;
        mute = 4'b1000;
        exp_q.push_back('{4'b1000, 10'd240, 10'd360});
        wait_start(10, n);
        check("err_confirm1", spawn_err, 0);
        tick();
        check("err_confirm2", spawn_err, 0);
        tick();
        check("err_set", spawn_err, 1);

        mute = 4'b0000;
        exp_q.push_back('{4'b1000, 10'd280, 10'd400});
        wait_start(8, n);
        check("err_sticky", spawn_err, 1);

        slot_alive[0] = 1'b0;
        exp_q.push_back('{4'b0001, 10'd320, 10'd350});
        wait_start(8, n);
        tick();
        check("done_before_end", done, 0);
        tick();
        check("done_at_end", done, 1);

        // restart from DONE kills all slots and rescans; kill_all then lands on the ISSUE cycle
        level_start = 1'b1;
        tick();
        level_start = 1'b0;
        check("restart_kill", last_kill, 4'b1111);
        check("restart_done_clr", done, 0);
        tick();
        tick();
        kill_all = 1'b1;
        tick();
        kill_all = 1'b0;
        check("killall_start", last_start, 0);
        check("killall_kill", last_kill, 4'b1111);
        check("killall_spawnX_latched", spawnX, 240);
        check("killall_scroll", scroll_col, 0);
        check("killall_keeps_err", spawn_err, 1);
        repeat (5) tick();
        check("idle_no_start", last_start, 0);

        // reset during ISSUE must suppress start
        level_start = 1'b1;
        tick();
        level_start = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
        tick();
        check("reset_mid_start", last_start, 0);
        check("reset_spawnX", spawnX, 0);
        check("reset_spawn_err", spawn_err, 0);
        Reset = 1'b0;
        repeat (5) tick();

        repeat (256) frame();
        check("scroll_saturate", scroll_col, 8'hFE);
        kill_all = 1'b1;
        tick();
        kill_all = 1'b0;
        check("scroll_killall_clr", scroll_col, 0);

        check("exp_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
